// File: rtl/tmds_decoder.sv
// Receive side of one DVI/TMDS lane: recovers the 10-bit symbol boundary by hunting
// for control tokens in the raw deserializer words, then decodes data and control symbols.
module tmds_decoder #(
  parameter int LOCK_COUNT    = 8,
  parameter int SEARCH_WINDOW = 4096,
  parameter int LOSS_WINDOW   = 4096,
  parameter int CNT_W         = 13
) (
  input  logic       pixclk,
  input  logic       rst,
  input  logic [9:0] raw_word,
  output logic [7:0] vd,
  output logic [1:0] cd,
  output logic       vde,
  output logic       locked,
  output logic [3:0] offset,
  output logic [7:0] loss_cnt
);

  localparam int STREAK_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SLIP,
    ST_LOCKED
  } state_t;

  state_t              state, state_nxt;
  logic [9:0]          raw_q;
  logic [9:0]          sym_q;
  logic [STREAK_W-1:0] streak, streak_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [3:0]          offset_nxt, offset_inc;
  logic [7:0]          loss_nxt;

  logic [19:0] window;
  logic [4:0]  sym_top;
  logic [9:0]  symbol;

  // Two consecutive words hold every possible 10-bit phase; offset 0 is raw_word itself.
  assign window  = {raw_word, raw_q};
  assign sym_top = 5'd19 - {1'b0, offset};
  assign symbol  = window[sym_top -: 10];

  logic       is_token;
  logic [1:0] tok_cd;
  logic [7:0] d_unmasked;
  logic [7:0] data_byte;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    is_token = 1'b1;
    tok_cd   = 2'b00;
    case (sym_q)
      10'b1101010100: tok_cd = 2'b00;
      10'b0010101011: tok_cd = 2'b01;
      10'b0101010100: tok_cd = 2'b10;
      10'b1010101011: tok_cd = 2'b11;
      default:        is_token = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  assign d_unmasked = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
  assign data_byte  = {(d_unmasked[7:1] ^ d_unmasked[6:0]) ^ {7{~sym_q[8]}}, d_unmasked[0]};

  assign offset_inc = (offset == 4'd9) ? 4'd0 : offset + 4'd1;

  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    cnt_nxt    = cnt;
    offset_nxt = offset;
    loss_nxt   = loss_cnt;
    case (state)
      ST_SEARCH: begin
        // Lock takes priority over a timer expiry on the same cycle.
        if (is_token && streak == STREAK_W'(LOCK_COUNT - 1)) begin
          state_nxt  = ST_LOCKED;
          streak_nxt = '0;
          cnt_nxt    = '0;
        end else if (cnt == CNT_W'(SEARCH_WINDOW - 1)) begin
          state_nxt  = ST_SLIP;
          offset_nxt = offset_inc;
          streak_nxt = '0;
          cnt_nxt    = '0;
        end else begin
          streak_nxt = is_token ? streak + STREAK_W'(1) : '0;
          cnt_nxt    = cnt + CNT_W'(1);
        end
      end
      // sym_q still carries the old-offset symbol here, so it is ignored.
      ST_SLIP: state_nxt = ST_SEARCH;
      ST_LOCKED: begin
        if (is_token) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_W'(LOSS_WINDOW - 1)) begin
          state_nxt  = ST_SLIP;
          offset_nxt = offset_inc;
          streak_nxt = '0;
          cnt_nxt    = '0;
          loss_nxt   = (loss_cnt == 8'hFF) ? loss_cnt : loss_cnt + 8'd1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_SEARCH;
    endcase
  end

  always_ff @(posedge pixclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: the pipeline registers are reset as well, so no stale symbol reaches the FSM after rst.
      raw_q    <= '0;
      sym_q    <= '0;
      state    <= ST_SEARCH;
      streak   <= '0;
      cnt      <= '0;
      offset   <= '0;
      loss_cnt <= '0;
      locked   <= 1'b0;
      vd       <= '0;
      cd       <= '0;
      vde      <= 1'b0;
    end else begin
      raw_q    <= raw_word;
      sym_q    <= symbol;
      state    <= state_nxt;
      streak   <= streak_nxt;
      cnt      <= cnt_nxt;
      offset   <= offset_nxt;
      loss_cnt <= loss_nxt;
      locked   <= (state_nxt == ST_LOCKED);
      // Outputs are gated by the same lock value that becomes visible on this edge.
      if (state_nxt != ST_LOCKED) begin
        vd  <= '0;
        cd  <= '0;
        vde <= 1'b0;
      end else if (is_token) begin
        vd  <= '0;
        cd  <= tok_cd;
        vde <= 1'b0;
      end else begin
        vd  <= data_byte;
        vde <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Randomized and directed bench for tmds_decoder: a behavioural lane model queues the
// expected outputs per clock edge and a monitor process compares them against the DUT.
module tb_tmds_decoder;

  localparam int LOCK_N = 8;
  localparam int SW     = 16;
  localparam int LW     = 32;

  localparam logic [9:0] TOK0 = 10'h354;  // 1101010100 -> cd 00
  localparam logic [9:0] TOK1 = 10'h0AB;  // 0010101011 -> cd 01
  localparam logic [9:0] TOK2 = 10'h154;  // 0101010100 -> cd 10
  localparam logic [9:0] TOK3 = 10'h2AB;  // 1010101011 -> cd 11

  logic       pixclk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] raw_word = '0;
  logic [7:0] vd;
  logic [1:0] cd;
  logic       vde;
  logic       locked;
  logic [3:0] offset;
  logic [7:0] loss_cnt;

  tmds_decoder #(
    .LOCK_COUNT   (LOCK_N),
    .SEARCH_WINDOW(SW),
    .LOSS_WINDOW  (LW),
    .CNT_W        (6)
  ) dut (
    .pixclk  (pixclk),
    .rst     (rst),
    .raw_word(raw_word),
    .vd      (vd),
    .cd      (cd),
    .vde     (vde),
    .locked  (locked),
    .offset  (offset),
    .loss_cnt(loss_cnt)
  );

  always #5 pixclk = ~pixclk;

  typedef struct packed {
    logic [7:0] vd;
    logic [1:0] cd;
    logic       vde;
    logic       locked;
    logic [3:0] offset;
    logic [7:0] loss;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // ---------------- behavioural lane model ----------------
  typedef enum int {HUNT, PAUSE, ALIGNED} mode_t;
  mode_t      m_mode = HUNT;
  int         m_off = 0, m_run = 0, m_idle = 0, m_loss = 0;
  logic [9:0] m_prev = '0, m_sym = '0;
  obs_t       m_out = '0;

  function automatic int token_cd(input logic [9:0] s);
    if (s == TOK0) return 0;
    if (s == TOK1) return 1;
    if (s == TOK2) return 2;
    if (s == TOK3) return 3;
    return -1;
  endfunction

  function automatic logic [7:0] tmds_data(input logic [9:0] q);
    logic [7:0] d, v;
    d    = q[9] ? ~q[7:0] : q[7:0];
    v[0] = d[0];
    for (int i = 1; i < 8; i++) v[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return v;
  endfunction

  task automatic model_step(input logic r, input logic [9:0] w);
    obs_t       o;
    int         c;
    logic [19:0] win;
    logic [9:0] nsym;
    o = m_out;
    if (r) begin
      m_mode = HUNT; m_off = 0; m_run = 0; m_idle = 0; m_loss = 0;
      m_prev = '0; m_sym = '0; o = '0;
    end else begin
      c    = token_cd(m_sym);
      win  = {w, m_prev};
      nsym = 10'(win >> (10 - m_off));
      case (m_mode)
        HUNT: begin
          m_run = (c >= 0) ? m_run + 1 : 0;
          if (m_run == LOCK_N) begin
            m_mode = ALIGNED; m_run = 0; m_idle = 0;
          end else if (m_idle == SW - 1) begin
            m_mode = PAUSE; m_off = (m_off + 1) % 10; m_run = 0; m_idle = 0;
          end else m_idle++;
        end
        PAUSE: m_mode = HUNT;
        ALIGNED: begin
          if (c >= 0) m_idle = 0;
          else if (m_idle == LW - 1) begin
            m_mode = PAUSE; m_off = (m_off + 1) % 10; m_run = 0; m_idle = 0;
            if (m_loss < 255) m_loss++;
          end else m_idle++;
        end
        default: m_mode = HUNT;
      endcase
      o.locked = (m_mode == ALIGNED);
      o.offset = 4'(m_off);
      o.loss   = 8'(m_loss);
      if (!o.locked) begin
        o.vd = '0; o.cd = '0; o.vde = 1'b0;
      end else if (c >= 0) begin
        o.vd = '0; o.cd = 2'(c); o.vde = 1'b0;
      end else begin
        o.vd = tmds_data(m_sym); o.vde = 1'b1;
      end
      m_sym  = nsym;
      m_prev = w;
    end
    m_out = o;
    exp_q.push_back(o);
  endtask

  // ---------------- stimulus helpers ----------------
  logic [9:0] s_prev = '0;

  task automatic tick(input logic r, input logic [9:0] w);
    @(negedge pixclk);
    rst      = r;
    raw_word = w;
    model_step(r, w);
  endtask

  // Serializes symbol s into the raw stream so it appears at bit phase k.
  task automatic send_sym(input logic [9:0] s, input int k);
    logic [19:0] pair;
    pair   = {s, s_prev};
    s_prev = s;
    tick(1'b0, 10'(pair >> k));
  endtask

  task automatic settle();
    @(posedge pixclk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    obs_t e, a;
    forever begin
      @(posedge pixclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{vd: vd, cd: cd, vde: vde, locked: locked, offset: offset, loss: loss_cnt};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL scoreboard @%0t: got vd=%h cd=%0d vde=%b locked=%b offset=%0d loss=%0d, expected vd=%h cd=%0d vde=%b locked=%b offset=%0d loss=%0d",
                   $time, a.vd, a.cd, a.vde, a.locked, a.offset, a.loss,
                   e.vd, e.cd, e.vde, e.locked, e.offset, e.loss);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  logic [9:0] toks [4];
  int         seg_k;
  logic [9:0] seg_t, s;

  initial begin
    toks = '{TOK0, TOK1, TOK2, TOK3};
    tick(1'b1, '0);
    tick(1'b1, '0);
    settle();
    check("reset_locked", locked, 0);
    check("reset_vde", vde, 0);

    // Lock on a steady token at offset 0.
    repeat (10) tick(1'b0, TOK0);
    settle();
    check("t1_locked", locked, 1);
    check("t1_offset", offset, 0);
    check("t1_cd", cd, 0);
    check("t1_vde", vde, 0);

    // Data decode of 0x100 and 0x200.
    tick(1'b0, 10'h100);
    tick(1'b0, 10'h200);
    settle();
    check("t3_vd_100", vd, 8'h00);
    check("t3_vde_100", vde, 1);
    tick(1'b0, TOK0);
    settle();
    check("t3_vd_200", vd, 8'hFF);
    check("t3_vde_200", vde, 1);
    tick(1'b0, TOK0);

    // Token arriving exactly on the watchdog-expiry cycle keeps lock.
    repeat (31) tick(1'b0, 10'h100);
    tick(1'b0, TOK0);
    tick(1'b0, TOK0);
    settle();
    check("t5_locked", locked, 1);
    check("t5_loss", loss_cnt, 0);

    // Watchdog expiry drops lock and advances the offset.
    repeat (35) tick(1'b0, 10'h100);
    settle();
    check("t4_locked", locked, 0);
    check("t4_loss", loss_cnt, 1);
    check("t4_offset", offset, 1);

    // Relock at phase 5, then reset mid-lock.
    s_prev = TOK0;
    repeat (120) send_sym(TOK0, 5);
    settle();
    check("t6_locked_pre", locked, 1);
    check("t6_offset_pre", offset, 5);
    tick(1'b1, TOK0);
    settle();
    check("t6_locked", locked, 0);
    check("t6_offset", offset, 0);
    check("t6_vd", vd, 0);
    check("t6_vde", vde, 0);
    check("t6_loss", loss_cnt, 0);

    // Search across offsets to a token at phase 3.
    s_prev = TOK2;
    repeat (120) send_sym(TOK2, 3);
    settle();
    check("t2_offset", offset, 3);
    check("t2_locked", locked, 1);
    check("t2_cd", cd, 2);

    // Randomized segments: token-rich at a random phase, then sparse tokens among data.
    for (int seg = 0; seg < 8; seg++) begin
      seg_k = $urandom_range(0, 9);
      seg_t = toks[$urandom_range(0, 3)];
      for (int i = 0; i < 260; i++) begin
        if (i < 200) s = ($urandom_range(0, 15) != 0) ? seg_t : 10'($urandom);
        else         s = ($urandom_range(0, 39) == 0) ? seg_t : 10'($urandom);
        if ($urandom_range(0, 999) == 0) tick(1'b1, 10'($urandom));
        else send_sym(s, seg_k);
      end
    end

    repeat (4) @(posedge pixclk);
    #2;
    check("scoreboard_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
